// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-stage branch predictor: mode encoding, entry layout, counter init.
// Pure declarations; no logic, no latency, no flow control.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    BP_STATIC  = 2'd0,
    BP_BIMODAL = 2'd1,
    BP_GSHARE  = 2'd2
  } bp_mode_e;

  // Widest legal tag and counter; narrower configurations zero-extend into these fields.
  localparam int TAG_MAX = 30;
  localparam int CTR_MAX = 4;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [31:1]        target;
    logic               is_jump;
    logic [CTR_MAX-1:0] ctr;
  } bp_entry_t;

  function automatic int ctr_weak_taken(input int bits);
    return 1 << (bits - 1);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down direction counter with load; one cycle to update, never stalls.
// Load wins over inc/dec; reset returns to RST_VAL.
module bp_sat_counter #(
  parameter int                  CTR_BITS = 2,
  parameter logic [CTR_BITS-1:0] RST_VAL  = '0,
  parameter logic [CTR_BITS-1:0] LOAD_VAL = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CTR_BITS-1:0] ctr_o
);

  localparam logic [CTR_BITS-1:0] CTR_FULL = '1;

  logic [CTR_BITS-1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (load_i) begin
      ctr_d = LOAD_VAL;
    end else if (inc_i && (ctr_q != CTR_FULL)) begin
      ctr_d = ctr_q + CTR_BITS'(1);
    end else if (dec_i && (ctr_q != '0)) begin
      ctr_d = ctr_q - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ctr_q <= RST_VAL;
    else       ctr_q <= ctr_d;
  end

  assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_predictor.sv
// BTB + saturating-counter predictor: zero-latency lookup, updates visible the next cycle.
// No backpressure; one resolution per cycle, rst > bp_clear > update.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter int MODE     = 1,
  parameter int GHR_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bp_clear,
  input  logic                lookup_valid,
  input  logic [31:0]         lookup_pc,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic                upd_is_jump,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_mispredict,
  output logic [31:0]         perf_lookups,
  output logic [31:0]         perf_mispred
);

  localparam int       IDX_W  = $clog2(ENTRIES);
  localparam bp_mode_e MODE_E = bp_mode_e'(MODE[1:0]);

  if (ENTRIES < 4 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("ENTRIES must be a power of two >= 4");
  end
  if (TAG_BITS < 1 || TAG_BITS > 30 - IDX_W) begin : g_bad_tag
    $error("TAG_BITS out of range");
  end
  if (CTR_BITS < 1 || CTR_BITS > CTR_MAX) begin : g_bad_ctr
    $error("CTR_BITS out of range");
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("MODE must be 0, 1 or 2");
  end
  if (GHR_BITS < 1 || GHR_BITS > IDX_W) begin : g_bad_ghr
    $error("GHR_BITS out of range");
  end

  logic [ENTRIES-1:0]  valid_q;
  logic [ENTRIES-1:0]  jump_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:1]         target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_w    [ENTRIES];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         perf_lk_q, perf_mp_q;

  logic [IDX_W-1:0]    lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic                lk_hit, lk_dir, up_hit, tbl_we, wr_en;
  bp_entry_t           rd;
  logic                unused_bits;

  assign lk_tag = lookup_pc[IDX_W+TAG_BITS+1:IDX_W+2];
  assign up_tag = upd_pc[IDX_W+TAG_BITS+1:IDX_W+2];

  always_comb begin
    lk_idx = lookup_pc[IDX_W+1:2];
    up_idx = upd_pc[IDX_W+1:2];
    if (MODE_E == BP_GSHARE) begin
      lk_idx = lk_idx ^ IDX_W'(ghr_q);
      up_idx = up_idx ^ IDX_W'(upd_ghr);
    end
  end

  always_comb begin
    rd         = '0;
    rd.valid   = valid_q[lk_idx];
    rd.tag     = TAG_MAX'(tag_q[lk_idx]);
    rd.target  = target_q[lk_idx];
    rd.is_jump = jump_q[lk_idx];
    rd.ctr     = CTR_MAX'(ctr_w[lk_idx]);
  end

  assign lk_hit      = rd.valid && (rd.tag == TAG_MAX'(lk_tag));
  assign lk_dir      = rd.is_jump || ((rd.ctr >> (CTR_BITS - 1)) != '0);
  assign pred_taken  = (MODE_E != BP_STATIC) && !rst && lk_hit && lk_dir;
  assign pred_target = pred_taken ? {rd.target, 1'b0} : 32'h0;
  assign pred_ghr    = ghr_q;

  // A taken resolution writes the entry whether it hit or allocated; tag rewrite on a hit is a no-op.
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign tbl_we = upd_valid && (MODE_E != BP_STATIC) && !rst && !bp_clear;
  assign wr_en  = tbl_we && upd_taken;

  always_ff @(posedge clk) begin
    if (rst || bp_clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target[31:1];
      jump_q[up_idx]   <= upd_is_jump;
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = tbl_we && (up_idx == IDX_W'(i));
    bp_sat_counter #(
      .CTR_BITS (CTR_BITS),
      .RST_VAL  (CTR_BITS'(ctr_weak_taken(CTR_BITS) - 1)),
      .LOAD_VAL (CTR_BITS'(ctr_weak_taken(CTR_BITS)))
    ) u_ctr (
      .clk_i  (clk),
      .rst_i  (rst),
      .load_i (sel && !up_hit && upd_taken),
      .inc_i  (sel && up_hit && upd_taken),
      .dec_i  (sel && up_hit && !upd_taken),
      .ctr_o  (ctr_w[i])
    );
  end

  always_comb begin
    ghr_d = ghr_q;
    if (bp_clear) begin
      ghr_d = '0;
    end else if ((MODE_E == BP_GSHARE) && upd_valid && !upd_is_jump) begin
      ghr_d = GHR_BITS'({ghr_q, upd_taken});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q     <= '0;
      perf_lk_q <= '0;
      perf_mp_q <= '0;
    end else begin
      ghr_q     <= ghr_d;
      perf_lk_q <= perf_lk_q + 32'(lookup_valid);
      perf_mp_q <= perf_mp_q + 32'(upd_valid && upd_mispredict);
    end
  end

  assign perf_lookups = perf_lk_q;
  assign perf_mispred = perf_mp_q;

  // PC bits outside index/tag and the target's bit 0 carry no prediction state.
  assign unused_bits = ^{lookup_pc, upd_pc, upd_target};

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: static, bimodal and gshare instances share stimulus.
// Directed scenarios use literal expectations; the random phase uses a table model.
module tb_branch_predictor;

  localparam int ENT  = 64;
  localparam int TB   = 8;
  localparam int CB   = 2;
  localparam int GB   = 6;
  localparam int CMAX = (1 << CB) - 1;
  localparam int WT   = 1 << (CB - 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, bp_clear = 1'b0, lookup_valid = 1'b0;
  logic [31:0]   lookup_pc = '0;
  logic          upd_valid = 1'b0, upd_taken = 1'b0, upd_is_jump = 1'b0, upd_mispredict = 1'b0;
  logic [31:0]   upd_pc = '0, upd_target = '0;
  logic [GB-1:0] upd_ghr = '0;

  logic          pt  [3];
  logic [31:0]   ptg [3];
  logic [GB-1:0] pg  [3];
  logic [31:0]   plk [3];
  logic [31:0]   pmp [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    branch_predictor #(
      .ENTRIES(ENT), .TAG_BITS(TB), .CTR_BITS(CB), .MODE(g), .GHR_BITS(GB)
    ) u_dut (
      .clk(clk), .rst(rst), .bp_clear(bp_clear),
      .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .pred_taken(pt[g]), .pred_target(ptg[g]), .pred_ghr(pg[g]),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_is_jump(upd_is_jump), .upd_ghr(upd_ghr),
      .upd_mispredict(upd_mispredict),
      .perf_lookups(plk[g]), .perf_mispred(pmp[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: one table per mode, plain integers.
  bit          m_val [3][ENT];
  int unsigned m_tag [3][ENT];
  int unsigned m_tgt [3][ENT];
  bit          m_jmp [3][ENT];
  int          m_ctr [3][ENT];
  int unsigned m_ghr [3];
  int unsigned m_lk  [3];
  int unsigned m_mp  [3];

  function automatic int m_idx(input int m, input logic [31:0] pc, input int unsigned g);
    int i;
    i = int'((pc / 4) % ENT);
    if (m == 2) i = i ^ int'(g);
    return i;
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return (pc / (4 * ENT)) % (1 << TB);
  endfunction

  function automatic void m_pred(input int m, input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    int i;
    i  = m_idx(m, pc, m_ghr[m]);
    tk = (m != 0) && !rst && m_val[m][i] && (m_tag[m][i] == m_tagof(pc)) &&
         (m_jmp[m][i] || (m_ctr[m][i] >= WT));
    tg = tk ? m_tgt[m][i] : 32'h0;
  endfunction

  task automatic m_step();
    for (int m = 0; m < 3; m++) begin
      if (rst) begin
        for (int e = 0; e < ENT; e++) begin
          m_val[m][e] = 1'b0;
          m_ctr[m][e] = WT - 1;
        end
        m_ghr[m] = 0; m_lk[m] = 0; m_mp[m] = 0;
      end else begin
        m_lk[m] += 32'(lookup_valid);
        m_mp[m] += 32'(upd_valid && upd_mispredict);
        if (bp_clear) begin
          for (int e = 0; e < ENT; e++) m_val[m][e] = 1'b0;
          m_ghr[m] = 0;
        end else if (upd_valid) begin
          if (m != 0) begin
            int i;
            bit hit;
            i   = m_idx(m, upd_pc, upd_ghr);
            hit = m_val[m][i] && (m_tag[m][i] == m_tagof(upd_pc));
            if (hit) begin
              if (upd_taken) m_ctr[m][i] = (m_ctr[m][i] < CMAX) ? m_ctr[m][i] + 1 : CMAX;
              else           m_ctr[m][i] = (m_ctr[m][i] > 0) ? m_ctr[m][i] - 1 : 0;
            end else if (upd_taken) begin
              m_val[m][i] = 1'b1;
              m_tag[m][i] = m_tagof(upd_pc);
              m_ctr[m][i] = WT;
            end
            if (upd_taken) begin
              m_tgt[m][i] = upd_target & 32'hFFFF_FFFE;
              m_jmp[m][i] = upd_is_jump;
            end
          end
          if (m == 2 && !upd_is_jump) m_ghr[2] = ((m_ghr[2] << 1) | 32'(upd_taken)) % (1 << GB);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    rst = 1'b0; bp_clear = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg, input logic j);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tg;
    upd_is_jump = j; upd_ghr = '0; upd_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    look($urandom);
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (pt[g] !== 1'b0) begin
        n_fail++; $display("FAIL reset_during_rst dut%0d: taken=%0b want 0", g, pt[g]);
      end
    end
    tick();
    rst = 1'b1;
    tick();
    look($urandom);
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if ({pt[g], ptg[g], pg[g], plk[g], pmp[g]} !== '0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: taken=%0b tgt=%h ghr=%h lk=%0d mp=%0d want all 0",
                 g, pt[g], ptg[g], pg[g], plk[g], pmp[g]);
      end
    end
  endtask

  task automatic test_bimodal();
    bit seq_t [12] = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
    bit seq_e [12] = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 12; i++) begin
      upd(32'h100, seq_t[i], 32'h140, 1'b0);
      tick();
      look(32'h100);
      n_checks++;
      if (pt[1] !== seq_e[i] || ptg[1] !== (seq_e[i] ? 32'h140 : 32'h0)) begin
        n_fail++;
        $display("FAIL bimodal_step%0d: taken=%0b tgt=%h want taken=%0b", i, pt[1], ptg[1], seq_e[i]);
      end
    end
  endtask

  task automatic test_alias();
    upd(32'h200, 1'b1, 32'h240, 1'b0);
    tick();
    look(32'h100);
    n_checks++;
    if (pt[1] !== 1'b0 || ptg[1] !== 32'h0) begin
      n_fail++; $display("FAIL alias_evicted: taken=%0b tgt=%h want 0/0", pt[1], ptg[1]);
    end
    look(32'h200);
    n_checks++;
    if (pt[1] !== 1'b1 || ptg[1] !== 32'h240) begin
      n_fail++; $display("FAIL alias_new: taken=%0b tgt=%h want 1/240", pt[1], ptg[1]);
    end
  endtask

  task automatic test_jump();
    int unsigned g0;
    g0 = m_ghr[2];
    upd(32'h80, 1'b1, 32'h300, 1'b1);
    tick();
    look(32'h80);
    n_checks++;
    if (pt[1] !== 1'b1 || ptg[1] !== 32'h300) begin
      n_fail++; $display("FAIL jal_pred: taken=%0b tgt=%h want 1/300", pt[1], ptg[1]);
    end
    n_checks++;
    if (pg[2] !== GB'(g0)) begin
      n_fail++; $display("FAIL jal_ghr_held: ghr=%h want %h", pg[2], GB'(g0));
    end
    // Counter driven to zero, jump flag must still force taken.
    for (int i = 0; i < 2; i++) begin
      upd(32'h80, 1'b0, 32'h0, 1'b0);
      tick();
    end
    look(32'h80);
    n_checks++;
    if (pt[1] !== 1'b1 || ptg[1] !== 32'h300) begin
      n_fail++; $display("FAIL jump_always_taken: taken=%0b tgt=%h want 1/300", pt[1], ptg[1]);
    end
    upd(32'h80, 1'b1, 32'h301, 1'b1);
    tick();
    look(32'h80);
    n_checks++;
    if (pt[1] !== 1'b1 || ptg[1] !== 32'h300) begin
      n_fail++; $display("FAIL jalr_bit0: taken=%0b tgt=%h want 1/300", pt[1], ptg[1]);
    end
  endtask

  task automatic test_gshare();
    int   misses;
    logic mt;
    logic [31:0] mg;
    misses = 0;
    for (int k = 0; k < 24; k++) begin
      logic          outcome, pt_s;
      logic [GB-1:0] g_s;
      outcome = (k % 2 == 0);
      look(32'h400);
      pt_s = pt[2];
      g_s  = pg[2];
      m_pred(2, 32'h400, mt, mg);
      n_checks++;
      if (pt_s !== mt) begin
        n_fail++; $display("FAIL gshare_model k=%0d: taken=%0b want %0b", k, pt_s, mt);
      end
      if (k >= 12 && pt_s !== outcome) misses++;
      upd(32'h400, outcome, 32'h480, 1'b0);
      upd_ghr = g_s;
      upd_mispredict = (pt_s !== outcome);
      tick();
    end
    n_checks++;
    if (misses !== 0) begin
      n_fail++; $display("FAIL gshare_warm_mispredicts: got %0d want 0", misses);
    end
  endtask

  task automatic test_same_cycle();
    look(32'h400);
    upd(32'h400, 1'b1, 32'h4C0, 1'b0);
    #1;
    n_checks++;
    if (pt[1] !== 1'b0 || ptg[1] !== 32'h0) begin
      n_fail++; $display("FAIL same_cycle_old: taken=%0b tgt=%h want 0/0", pt[1], ptg[1]);
    end
    tick();
    look(32'h400);
    n_checks++;
    if (pt[1] !== 1'b1 || ptg[1] !== 32'h4C0) begin
      n_fail++; $display("FAIL same_cycle_next: taken=%0b tgt=%h want 1/4c0", pt[1], ptg[1]);
    end
  endtask

  task automatic test_clear_and_rst();
    logic [31:0] pcs [3] = '{32'h400, 32'h80, 32'h200};
    bp_clear = 1'b1;
    tick();
    lookup_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lookup_pc = pcs[i]; #1;
      n_checks++;
      if (pt[1] !== 1'b0 || pt[2] !== 1'b0) begin
        n_fail++; $display("FAIL clear_miss pc=%h: bimodal=%0b gshare=%0b want 0", pcs[i], pt[1], pt[2]);
      end
    end
    n_checks++;
    if (pg[2] !== '0) begin
      n_fail++; $display("FAIL clear_ghr: ghr=%h want 0", pg[2]);
    end
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (plk[g] !== m_lk[g] || pmp[g] !== m_mp[g] || plk[g] === 32'h0) begin
        n_fail++;
        $display("FAIL clear_perf_kept dut%0d: lk=%0d mp=%0d want %0d/%0d", g, plk[g], pmp[g], m_lk[g], m_mp[g]);
      end
    end
    upd(32'h600, 1'b1, 32'h640, 1'b0);
    rst = 1'b1;
    tick();
    look(32'h600);
    n_checks++;
    if (pt[1] !== 1'b0 || pt[2] !== 1'b0 || plk[1] !== 32'h0) begin
      n_fail++; $display("FAIL rst_drops_update: bimodal=%0b gshare=%0b lk=%0d want 0/0/0", pt[1], pt[2], plk[1]);
    end
  endtask

  task automatic test_static();
    int cnt;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      upd(32'h700, 1'b1, 32'h740, 1'b0);
      upd_valid      = 1'($urandom_range(0, 1));
      upd_mispredict = 1'($urandom_range(0, 1));
      if (upd_valid && upd_mispredict) cnt++;
      look(32'h700);
      n_checks++;
      if (pt[0] !== 1'b0 || ptg[0] !== 32'h0) begin
        n_fail++; $display("FAIL static_never_taken i=%0d: taken=%0b tgt=%h", i, pt[0], ptg[0]);
      end
      tick();
    end
    #1;
    n_checks++;
    if (pmp[0] !== 32'(cnt)) begin
      n_fail++; $display("FAIL static_mispred_count: got %0d want %0d", pmp[0], cnt);
    end
  endtask

  function automatic logic [31:0] pick_pc();
    return ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  task automatic test_random();
    logic        mt;
    logic [31:0] mg;
    for (int c = 0; c < 400; c++) begin
      rst            = ($urandom_range(0, 99) == 0);
      bp_clear       = ($urandom_range(0, 49) == 0);
      lookup_valid   = 1'($urandom_range(0, 1));
      lookup_pc      = pick_pc();
      upd_valid      = ($urandom_range(0, 2) != 0);
      upd_pc         = pick_pc();
      upd_is_jump    = ($urandom_range(0, 5) == 0);
      upd_taken      = upd_is_jump || ($urandom_range(0, 1) == 1);
      upd_target     = $urandom;
      upd_ghr        = GB'($urandom_range(0, 63));
      upd_mispredict = 1'($urandom_range(0, 1));
      #1;
      for (int g = 0; g < 3; g++) begin
        m_pred(g, lookup_pc, mt, mg);
        n_checks++;
        if (pt[g] !== mt) begin
          n_fail++; $display("FAIL rand_taken c=%0d dut%0d: got %0b want %0b", c, g, pt[g], mt);
        end
        n_checks++;
        if (ptg[g] !== mg) begin
          n_fail++; $display("FAIL rand_target c=%0d dut%0d: got %h want %h", c, g, ptg[g], mg);
        end
        n_checks++;
        if (pg[g] !== GB'(m_ghr[g])) begin
          n_fail++; $display("FAIL rand_ghr c=%0d dut%0d: got %h want %h", c, g, pg[g], GB'(m_ghr[g]));
        end
        n_checks++;
        if (plk[g] !== m_lk[g] || pmp[g] !== m_mp[g]) begin
          n_fail++;
          $display("FAIL rand_perf c=%0d dut%0d: lk=%0d mp=%0d want %0d/%0d", c, g, plk[g], pmp[g], m_lk[g], m_mp[g]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_bimodal();
    test_alias();
    test_jump();
    test_gshare();
    test_same_cycle();
    test_clear_and_rst();
    test_static();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
